// File: rtl/seq_detector.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector
//  Description : Serial detector for the bit pattern 0,1,1,0 (oldest first).
//                Four-state binary FSM. OVERLAP selects whether a hit may
//                share its trailing 0 with the next match.
//                Output form is chosen by macro SEQ_DETECTOR_REG_OUT_EN:
//                  undefined -> combinational Mealy flag (default)
//                  defined   -> registered flag, one cycle after the hit
//  Revision    : 1.0  initial release
// ============================================================================
module seq_detector #(
    parameter int OVERLAP = 1
) (
    input  logic x,
    input  logic clk,
    input  logic reset,
    output logic z
);

    localparam logic [1:0] c_S0 = 2'd0;  // nothing matched
    localparam logic [1:0] c_S1 = 2'd1;  // "0" matched
    localparam logic [1:0] c_S2 = 2'd2;  // "01" matched
    localparam logic [1:0] c_S3 = 2'd3;  // "011" matched

    // After a hit the trailing 0 may seed the next match, or be discarded
    localparam logic [1:0] c_S_AFTER_HIT = (OVERLAP != 0) ? c_S1 : c_S0;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       w_hit;

    // Hit is seen while the final 0 is on x with "011" already matched
    always_comb begin
        w_hit = (r_state == c_S3) && (x == 1'b0);
    end

    // Next-state selection; any unexpected encoding falls back to S0
    always_comb begin
        w_next_state = c_S0;
        case (r_state)
            c_S0:    w_next_state = x ? c_S0 : c_S1;
            c_S1:    w_next_state = x ? c_S2 : c_S1;
            c_S2:    w_next_state = x ? c_S3 : c_S1;
            c_S3:    w_next_state = x ? c_S0 : c_S_AFTER_HIT;
            default: w_next_state = c_S0;
        endcase
    end

    // State register, cleared immediately by the active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S0;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifdef SEQ_DETECTOR_REG_OUT_EN
    logic r_z;

    // Registered flag: captures the hit on the edge that samples the final 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_z <= 1'b0;
        end else begin
            r_z <= w_hit;
        end
    end

    assign z = r_z;
`else
    // Mealy flag straight from state and current input
    assign z = w_hit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector
//  Description : Scoreboard bench for seq_detector. Two instances (OVERLAP=1
//                and OVERLAP=0) see the same stream. A reference model based
//                on a sliding window of recent bits pushes expected flags
//                into a queue; a monitor compares them each falling edge.
//                Honours SEQ_DETECTOR_REG_OUT_EN for the output timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_detector;

    typedef struct packed {
        logic z_ov;
        logic z_no;
    } exp_t;

    logic clk;
    logic reset;
    logic x;
    logic z_ov;
    logic z_no;

    exp_t exp_q[$];
    int   tests;
    int   fails;

    // Reference model state: bits received since the last restart
    logic hist_ov[$];
    logic hist_no[$];
    logic prev_ov;
    logic prev_no;

    seq_detector #(.OVERLAP(1)) u_ov (
        .x     (x),
        .clk   (clk),
        .reset (reset),
        .z     (z_ov)
    );

    seq_detector #(.OVERLAP(0)) u_no (
        .x     (x),
        .clk   (clk),
        .reset (reset),
        .z     (z_no)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // True when the last four bits of a window spell 0,1,1,0
    function automatic logic window_hit(input logic h[$]);
        logic hit;
        hit = 1'b0;
        if (h.size() >= 4) begin
            hit = (h[h.size()-4] == 1'b0) && (h[h.size()-3] == 1'b1) &&
                  (h[h.size()-2] == 1'b1) && (h[h.size()-1] == 1'b0);
        end
        return hit;
    endfunction

    // Push the flag values expected during the current cycle
    task automatic push_expect(input logic hit_ov, input logic hit_no);
        exp_t e;
`ifdef SEQ_DETECTOR_REG_OUT_EN
        e.z_ov  = prev_ov;
        e.z_no  = prev_no;
        prev_ov = hit_ov;
        prev_no = hit_no;
`else
        e.z_ov = hit_ov;
        e.z_no = hit_no;
`endif
        exp_q.push_back(e);
    endtask

    // One serial bit, driven away from the sampling edge
    task automatic drive(input logic xb);
        logic h1;
        logic h0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        x     = xb;
        hist_ov.push_back(xb);
        if (hist_ov.size() > 4) void'(hist_ov.pop_front());
        hist_no.push_back(xb);
        if (hist_no.size() > 4) void'(hist_no.pop_front());
        h1 = window_hit(hist_ov);
        h0 = window_hit(hist_no);
        if (h0) hist_no.delete();
        push_expect(h1, h0);
    endtask

    task automatic model_clear();
        hist_ov.delete();
        hist_no.delete();
        prev_ov = 1'b0;
        prev_no = 1'b0;
        exp_q.push_back('0);
    endtask

    // Hold reset for n whole cycles with random x (don't-care)
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            x     = 1'($urandom_range(0, 1));
            model_clear();
        end
    endtask

    // Put the final 0 on x, then drop reset between clock edges
    task automatic mid_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        x     = 1'b0;
        #2;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic drive_stream(input logic [15:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            drive(bits[i]);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (z_ov !== e.z_ov) begin
                    fails++;
                    $display("FAIL z_overlap t=%0t actual=%b required=%b", $time, z_ov, e.z_ov);
                end
                tests++;
                if (z_no !== e.z_no) begin
                    fails++;
                    $display("FAIL z_nonoverlap t=%0t actual=%b required=%b", $time, z_no, e.z_no);
                end
            end
        end
    end

    initial begin
        tests   = 0;
        fails   = 0;
        prev_ov = 1'b0;
        prev_no = 1'b0;
        reset   = 1'b0;
        x       = 1'b0;

        do_reset(2);
        drive_stream(16'b00110, 5);            // hit on 5th bit only
        do_reset(1);
        drive_stream(16'b0110110, 7);          // two hits vs one hit
        do_reset(1);
        drive_stream(16'b1110111, 7);          // never hits
        do_reset(1);
        drive_stream(16'b000110, 6);           // repeated zeros hold S1
        do_reset(1);
        drive_stream(16'b011, 3);              // reach S3
        mid_reset();                           // async clear with x=0
        do_reset(1);
        drive(1'b0);                           // fresh search, no hit
        drive_stream(16'b0110, 4);
        drive_stream(16'b0110, 4);
        drive_stream(16'b0110110110, 10);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset(1);
            end else if ($urandom_range(0, 3) == 0) begin
                drive_stream(16'b0110, 4);
            end else begin
                drive(1'($urandom_range(0, 1)));
            end
        end
        drive(1'b1);
        drive(1'b1);

        repeat (3) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter: OVERLAP, default 1, 1 = overlapping detection, 0 = non-overlapping (search restarts after each hit).
REQ-002 Port: clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: x  input  1  serial data bit, one bit sampled per rising clk edge.
REQ-005 Port: z  output  1  detection flag, high when the bit sequence 0,1,1,0 has been received.
REQ-006 Positional port order SHALL be (x, clk, reset, z) so positional instantiation binds correctly.

Function
REQ-007 Target sequence SHALL be the fixed 4-bit serial pattern 0,1,1,0, oldest bit first.
REQ-008 The FSM SHALL use 4 states, binary encoded, with 2-bit state and next_state registers:
  - S0: nothing matched.
  - S1: "0" matched.
  - S2: "01" matched.
  - S3: "011" matched.
REQ-009 S0 transitions: x=0 -> S1; x=1 -> S0.
REQ-010 S1 transitions: x=0 -> S1; x=1 -> S2.
REQ-011 S2 transitions: x=0 -> S1; x=1 -> S3.
REQ-012 S3 transitions: x=1 -> S0; x=0 -> detection, next state S1 if OVERLAP=1, S0 if OVERLAP=0.
REQ-013 Default (Mealy) output: z = (state==S3) && (x==0), combinational.
  - z is valid before the rising edge that samples the final 0.
REQ-014 z SHALL be 0 in every state/input combination other than REQ-013.
REQ-015 An unused or illegal state encoding SHALL transition to S0 on the next edge with z=0.
REQ-016 Back-to-back hits: stream 0,1,1,0,1,1,0 with OVERLAP=1 SHALL produce two detections; with OVERLAP=0 it SHALL produce exactly one.
REQ-017 Repeated zeros SHALL hold S1, so stream 0,0,0,1,1,0 detects on the final bit.

Reset
REQ-018 reset=0 SHALL force state to S0 immediately, independent of clk.
REQ-019 z SHALL be 0 while reset=0, in both output configurations.
REQ-020 Reset mid-sequence, including from S3 with x=0, SHALL discard partial-match history.
REQ-021 After reset deasserts, the first sampled bit SHALL be treated as the first bit of a new search.
REQ-022 Reset release SHALL be synchronized to clk by the integrator; x is don't-care during reset.

Configuration
REQ-023 Macro SEQ_DETECTOR_REG_OUT_EN selects the output form.
  - Defined: z is a flip-flop, set on the edge that samples the final 0 of a match and high for exactly one clk cycle afterwards (one cycle later than Mealy), cleared asynchronously by reset.
  - Undefined: z is combinational per REQ-013.
  - State transitions are identical in both builds.

Verification
REQ-024 Reset=0, then release; x stream 0,0,1,1,0 (one bit per edge) -> z asserts only for the 5th bit; z=0 for bits 1-4.
REQ-025 OVERLAP=1, x stream 0,1,1,0,1,1,0 -> z=1 on bits 4 and 7 only; OVERLAP=0, same stream -> z=1 on bit 4 only.
REQ-026 x stream 1,1,1,0,1,1,1 -> z never asserts; state returns to S0 after each "0111".
REQ-027 x stream 0,1,1 (state S3), then reset=0 asynchronously mid-cycle -> z=0 at once; after release, x=0 does not assert z.
REQ-028 Both builds, x stream 0,1,1,0 -> Mealy z high during the 4th bit cycle; SEQ_DETECTOR_REG_OUT_EN build z high for exactly the following cycle.
